// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary value accumulator: step direction encoding,
// default acceleration settings and a small range-check helper.
package rotary_pkg;

  // Decoded step direction for one cycle.
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2
  } dir_e;

  localparam int unsigned DEF_ACCEL_WINDOW    = 100000;
  localparam int unsigned DEF_ACCEL_THRESHOLD = 4;
  localparam int unsigned DEF_ACCEL_STEP      = 4;

  // True when lo <= v <= hi.
  function automatic logic in_range(input longint unsigned v,
                                    input longint unsigned lo,
                                    input longint unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/rotary_accel_tracker.sv
// Streak tracker for velocity-based acceleration. Holds an idle timer and a
// same-direction streak count, and reports the step size for the current step.
// Only instantiated when ROTARY_ACCEL_EN is defined.
module rotary_accel_tracker
  import rotary_pkg::*;
#(
  parameter int unsigned ACCEL_WINDOW    = DEF_ACCEL_WINDOW,
  parameter int unsigned ACCEL_THRESHOLD = DEF_ACCEL_THRESHOLD,
  parameter int unsigned ACCEL_STEP      = DEF_ACCEL_STEP,
  parameter int unsigned STEP_W          = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  dir_e              step_dir,
  input  logic              clear,
  output logic [STEP_W-1:0] step_size
);

  localparam int unsigned TimerW  = (ACCEL_WINDOW < 1) ? 1 : $clog2(ACCEL_WINDOW + 1);
  localparam int unsigned StreakW = (ACCEL_THRESHOLD < 1) ? 1 : $clog2(ACCEL_THRESHOLD + 1);
  localparam logic [TimerW-1:0]  WindowMax = TimerW'(ACCEL_WINDOW);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(ACCEL_THRESHOLD);

  logic [TimerW-1:0]  timer_q;
  logic [StreakW-1:0] streak_q, streak_d;
  dir_e               last_dir_q;
  logic               is_step, continues;

  // Next streak including the current step; it also selects this step's size.
  always_comb begin
    streak_d  = streak_q;
    is_step   = (step_dir != DIR_NONE);
    continues = (step_dir == last_dir_q) && (timer_q < WindowMax);
    if (clear) begin
      streak_d = '0;
    end else if (is_step) begin
      if (!continues) begin
        streak_d = StreakW'(1);
      end else if (streak_q < StreakMax) begin
        streak_d = streak_q + StreakW'(1);
      end
    end
    step_size = (streak_d >= StreakMax) ? STEP_W'(ACCEL_STEP) : STEP_W'(1);
  end

  // Timer restarts on every step and holds once expired; reset starts expired.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q    <= WindowMax;
      streak_q   <= '0;
      last_dir_q <= DIR_NONE;
    end else begin
      streak_q <= streak_d;
      if (is_step && !clear) begin
        timer_q    <= '0;
        last_dir_q <= step_dir;
      end else if (timer_q < WindowMax) begin
        timer_q <= timer_q + TimerW'(1);
      end
    end
  end

endmodule

// File: rtl/rotary_value_accumulator.sv
// Integrates one-cycle rotary step flags into a bounded register value that
// either saturates or wraps at its limits. Define ROTARY_ACCEL_EN to build the
// streak-based acceleration; otherwise every step moves the value by one.
module rotary_value_accumulator
  import rotary_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned MIN_VALUE       = 0,
  parameter int unsigned MAX_VALUE       = 255,
  parameter int unsigned RESET_VALUE     = 0,
  parameter int unsigned WRAP            = 0,
  parameter int unsigned ACCEL_WINDOW    = DEF_ACCEL_WINDOW,
  parameter int unsigned ACCEL_THRESHOLD = DEF_ACCEL_THRESHOLD,
  parameter int unsigned ACCEL_STEP      = DEF_ACCEL_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_cw,
  input  logic             in_ccw,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             changed,
  output logic             at_min,
  output logic             at_max
);

  // Two guard bits keep sums and differences free of overflow.
  localparam int unsigned EW = WIDTH + 2;
  localparam logic [EW-1:0] MinX   = EW'(MIN_VALUE);
  localparam logic [EW-1:0] MaxX   = EW'(MAX_VALUE);
  localparam logic [EW-1:0] RangeX = EW'(MAX_VALUE - MIN_VALUE + 1);

  logic [WIDTH-1:0] value_q;
  logic             changed_q, at_min_q, at_max_q;
  dir_e             step_dir;
  logic             clear;
  logic [EW-1:0]    step_size;
  logic [EW-1:0]    cur, off, lv, tmp, next_x;
  logic [WIDTH-1:0] value_d;

  // Load discards steps; both flags at once is a null event that breaks a streak.
  always_comb begin
    step_dir = DIR_NONE;
    if (!load && (in_cw != in_ccw)) begin
      step_dir = in_cw ? DIR_CW : DIR_CCW;
    end
    clear = load || (in_cw && in_ccw);
  end

`ifdef ROTARY_ACCEL_EN
  rotary_accel_tracker #(
    .ACCEL_WINDOW   (ACCEL_WINDOW),
    .ACCEL_THRESHOLD(ACCEL_THRESHOLD),
    .ACCEL_STEP     (ACCEL_STEP),
    .STEP_W         (EW)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .step_dir (step_dir),
    .clear    (clear),
    .step_size(step_size)
  );
`else
  assign step_size = EW'(1);
`endif

  // Next value: clamp on load, otherwise saturating or wrapping step.
  always_comb begin
    cur    = EW'(value_q);
    off    = cur - MinX;
    lv     = EW'(load_value);
    tmp    = '0;
    next_x = cur;
    if (load) begin
      if (in_range(64'(lv), 64'(MinX), 64'(MaxX))) begin
        next_x = lv;
      end else if (lv < MinX) begin
        next_x = MinX;
      end else begin
        next_x = MaxX;
      end
    end else if (step_dir == DIR_CW) begin
      if (WRAP != 0) begin
        tmp = off + step_size;
        if (tmp >= RangeX) tmp = tmp - RangeX;
        next_x = MinX + tmp;
      end else begin
        tmp    = cur + step_size;
        next_x = (tmp > MaxX) ? MaxX : tmp;
      end
    end else if (step_dir == DIR_CCW) begin
      if (WRAP != 0) begin
        tmp    = (off >= step_size) ? (off - step_size) : (off + RangeX - step_size);
        next_x = MinX + tmp;
      end else begin
        next_x = (cur < MinX + step_size) ? MinX : (cur - step_size);
      end
    end
    value_d = WIDTH'(next_x);
  end

  // Value and status flags are all registered from the same next value.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q   <= WIDTH'(RESET_VALUE);
      changed_q <= 1'b0;
      at_min_q  <= (RESET_VALUE == MIN_VALUE);
      at_max_q  <= (RESET_VALUE == MAX_VALUE);
    end else begin
      value_q   <= value_d;
      changed_q <= (value_d != value_q);
      at_min_q  <= (EW'(value_d) == MinX);
      at_max_q  <= (EW'(value_d) == MaxX);
    end
  end

  assign value   = value_q;
  assign changed = changed_q;
  assign at_min  = at_min_q;
  assign at_max  = at_max_q;

endmodule

// File: tb/tb_rotary_value_accumulator.sv
// Directed bench for rotary_value_accumulator: saturating default unit, a
// wrapping 10..19 unit and a 9-bit unit for load clamping. Expected values for
// the acceleration sequences follow whether ROTARY_ACCEL_EN is defined.
module tb_rotary_value_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cw0 = 0, ccw0 = 0, ld0 = 0;
  logic [7:0] lv0 = 0, val0;
  logic       ch0, mn0, mx0;
  logic       cw1 = 0, ccw1 = 0, ld1 = 0;
  logic [7:0] lv1 = 0, val1;
  logic       ch1, mn1, mx1;
  logic       cw2 = 0, ccw2 = 0, ld2 = 0;
  logic [8:0] lv2 = 0, val2;
  logic       ch2, mn2, mx2;

  int n_tests = 0;
  int n_fail  = 0;

  rotary_value_accumulator #(
    .ACCEL_WINDOW(10)
  ) u_sat (
    .clk(clk), .rst(rst), .in_cw(cw0), .in_ccw(ccw0), .load(ld0), .load_value(lv0),
    .value(val0), .changed(ch0), .at_min(mn0), .at_max(mx0)
  );

  rotary_value_accumulator #(
    .MIN_VALUE(10), .MAX_VALUE(19), .RESET_VALUE(10), .WRAP(1)
  ) u_wrap (
    .clk(clk), .rst(rst), .in_cw(cw1), .in_ccw(ccw1), .load(ld1), .load_value(lv1),
    .value(val1), .changed(ch1), .at_min(mn1), .at_max(mx1)
  );

  rotary_value_accumulator #(
    .WIDTH(9), .MAX_VALUE(255)
  ) u_w9 (
    .clk(clk), .rst(rst), .in_cw(cw2), .in_ccw(ccw2), .load(ld2), .load_value(lv2),
    .value(val2), .changed(ch2), .at_min(mn2), .at_max(mx2)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One-cycle strobe on the selected unit; returns at the negedge after the edge.
  task automatic pulse(input int unit, input logic cw, input logic ccw, input logic ld,
                       input logic [8:0] lv);
    @(negedge clk);
    case (unit)
      0: begin cw0 = cw; ccw0 = ccw; ld0 = ld; lv0 = lv[7:0]; end
      1: begin cw1 = cw; ccw1 = ccw; ld1 = ld; lv1 = lv[7:0]; end
      default: begin cw2 = cw; ccw2 = ccw; ld2 = ld; lv2 = lv; end
    endcase
    @(negedge clk);
    cw0 = 0; ccw0 = 0; ld0 = 0;
    cw1 = 0; ccw1 = 0; ld1 = 0;
    cw2 = 0; ccw2 = 0; ld2 = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

`ifdef ROTARY_ACCEL_EN
  int slow_exp[8] = '{1, 2, 3, 7, 11, 15, 16, 15};
  int fast_exp[5] = '{30, 31, 32, 36, 40};
`else
  int slow_exp[8] = '{1, 2, 3, 4, 5, 6, 7, 6};
  int fast_exp[5] = '{30, 31, 32, 33, 34};
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    rst = 0;
    check("rst_value", val0, 0);
    check("rst_changed", ch0, 0);
    check("rst_at_min", mn0, 1);
    check("rst_at_max", mx0, 0);
    check("rst_wrap_value", val1, 10);
    check("rst_wrap_at_min", mn1, 1);

    for (int k = 1; k <= 3; k++) begin
      pulse(0, 1, 0, 0, 0);
      check("cw_value", val0, k);
      check("cw_changed", ch0, 1);
      idle(1);
      check("cw_changed_once", ch0, 0);
    end

    pulse(0, 0, 0, 1, 255);
    check("load255_value", val0, 255);
    check("load255_changed", ch0, 1);
    check("load255_at_max", mx0, 1);
    pulse(0, 1, 0, 0, 0);
    check("sat_max_value", val0, 255);
    check("sat_max_changed", ch0, 0);
    check("sat_max_at_max", mx0, 1);
    pulse(0, 0, 1, 0, 0);
    check("ccw_from_max", val0, 254);
    check("ccw_from_max_changed", ch0, 1);
    check("ccw_from_max_at_max", mx0, 0);
    pulse(0, 1, 1, 0, 0);
    check("null_value", val0, 254);
    check("null_changed", ch0, 0);

    pulse(1, 0, 0, 1, 19);
    check("wrap_load19", val1, 19);
    check("wrap_at_max", mx1, 1);
    pulse(1, 1, 0, 0, 0);
    check("wrap_up", val1, 10);
    check("wrap_up_changed", ch1, 1);
    check("wrap_up_at_min", mn1, 1);
    pulse(1, 0, 1, 0, 0);
    check("wrap_down", val1, 19);
    pulse(1, 0, 0, 1, 5);
    check("wrap_load_clamp_lo", val1, 10);

    pulse(2, 0, 0, 1, 300);
    check("w9_load_clamp_hi", val2, 255);
    check("w9_at_max", mx2, 1);
    check("w9_changed", ch2, 1);

    pulse(0, 0, 0, 1, 0);
    check("load0_value", val0, 0);
    for (int i = 0; i < 6; i++) begin
      pulse(0, 1, 0, 0, 0);
      check("slow_streak", val0, slow_exp[i]);
      idle(3);
    end
    idle(7);
    pulse(0, 1, 0, 0, 0);
    check("after_gap", val0, slow_exp[6]);
    pulse(0, 0, 1, 0, 0);
    check("reversal", val0, slow_exp[7]);

    pulse(0, 0, 0, 1, 29);
    check("load29", val0, 29);
    @(negedge clk);
    cw0 = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("fast_streak", val0, fast_exp[i]);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    cw0 = 0;
    check("rst_mid_value", val0, 0);
    check("rst_mid_changed", ch0, 0);
    check("rst_mid_at_min", mn0, 1);
    pulse(0, 1, 0, 0, 0);
    check("post_rst_step", val0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
